axi4lite_sram_responder: RTL and testbench

AXI4-Lite responder (subordinate) backed by a word-organised synchronous RAM; it is the memory-side counterpart of the core's instruction and data bus masters. It serves independent read and write channels, each with its own small state machine. It applies byte strobes on writes, answers out-of-range accesses with SLVERR, and provides fixed-latency, fully handshaked responses. It sits between the core's data/instruction buses and on-chip RAM.

---
 rtl/axi4lite_sram_responder.sv | 182 ++++++++++++++++++
 tb/tb_axi4lite_sram_responder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_sram_responder.sv
// AXI4-Lite subordinate backed by a word-organised synchronous RAM.
// It has independent read and write FSMs, byte strobes, and SLVERR for out-of-range accesses.
//
//   state  | meaning
//   R_IDLE | ready for a read address (arready=1)
//   R_RESP | read data presented, waiting for rready
//   W_IDLE | collecting AW and W in either order or together
//   W_RESP | write response presented, waiting for bready
module axi4lite_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;
    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;

    rd_state_t r_rstate, w_rstate_nxt;
    wr_state_t r_wstate, w_wstate_nxt;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [1:0]  r_bresp;
    logic        r_aw_got;
    logic        r_w_got;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic             w_ar_fire;
    logic             w_aw_fire;
    logic             w_w_fire;
    logic             w_commit;
    logic [31:0]      w_ar_off;
    logic             w_ar_hit;
    logic [IDX_W-1:0] w_ar_idx;
    logic [31:0]      w_waddr_eff;
    logic [31:0]      w_wdata_eff;
    logic [3:0]       w_wstrb_eff;
    logic [31:0]      w_wr_off;
    logic             w_wr_hit;
    logic [IDX_W-1:0] w_wr_idx;

    assign w_ar_fire = arvalid && arready;
    assign w_aw_fire = awvalid && awready;
    assign w_w_fire  = wvalid && wready;

    // Addresses below BASE_ADDR wrap to a huge offset and decode as out of range.
    assign w_ar_off = araddr - BASE_ADDR;
    assign w_ar_hit = (w_ar_off < SPAN);
    assign w_ar_idx = w_ar_off[IDX_W+1:2];

    // A beat arriving this cycle takes the place of a captured one that is still missing.
    assign w_waddr_eff = r_aw_got ? r_awaddr : awaddr;
    assign w_wdata_eff = r_w_got ? r_wdata : wdata;
    assign w_wstrb_eff = r_w_got ? r_wstrb : wstrb;
    assign w_wr_off    = w_waddr_eff - BASE_ADDR;
    assign w_wr_hit    = (w_wr_off < SPAN);
    assign w_wr_idx    = w_wr_off[IDX_W+1:2];
    assign w_commit    = !rst && (r_wstate == W_IDLE)
                         && (r_aw_got || w_aw_fire) && (r_w_got || w_w_fire);

    // Read FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_fire) w_rstate_nxt = R_RESP;
            R_RESP:  if (rready)    w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready = !rst && (r_rstate == R_IDLE);
        rvalid  = !rst && (r_rstate == R_RESP);
        rdata   = rst ? 32'h0 : r_rdata;
        rresp   = rst ? RESP_OKAY : r_rresp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_fire) begin
            r_rdata <= w_ar_hit ? r_mem[w_ar_idx] : 32'h0;
            r_rresp <= w_ar_hit ? RESP_OKAY : RESP_SLV;
        end
    end

    // Write FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (bready)   w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready = !rst && (r_wstate == W_IDLE) && !r_aw_got;
        wready  = !rst && (r_wstate == W_IDLE) && !r_w_got;
        bvalid  = !rst && (r_wstate == W_RESP);
        bresp   = rst ? RESP_OKAY : r_bresp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLV;
        end else begin
            if (w_aw_fire) begin
                r_aw_got <= 1'b1;
                r_awaddr <= awaddr;
            end
            if (w_w_fire) begin
                r_w_got <= 1'b1;
                r_wdata <= wdata;
                r_wstrb <= wstrb;
            end
        end
    end

    // Contents survive reset; a read on the same edge sees the pre-write word.
    always_ff @(posedge clk) begin
        if (w_commit && w_wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb_eff[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= w_wdata_eff[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_sram_responder.sv
// Bench for axi4lite_sram_responder: directed scenarios with literal expectations,
// then randomized traffic compared cycle by cycle against a transaction-level memory model.
module tb_axi4lite_sram_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    axi4lite_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_rpend = 0, m_rknown = 0, m_bpend = 0, m_aw_got = 0, m_w_got = 0;
    logic [31:0] m_rdata, m_awaddr, m_wdata;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;

    function automatic bit hit(input logic [31:0] a);
        return (a - BASE) < 32'(DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'(o >> 2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_rpend = 0; m_bpend = 0; m_aw_got = 0; m_w_got = 0;
        end else begin
            // read side first so a same-edge write is not yet visible
            if (!m_rpend) begin
                if (arvalid) begin
                    m_rpend = 1;
                    if (hit(araddr)) begin
                        m_rdata  = m_mem[widx(araddr)];
                        m_rknown = m_known[widx(araddr)];
                        m_rresp  = 2'b00;
                    end else begin
                        m_rdata = 32'h0; m_rknown = 1; m_rresp = 2'b10;
                    end
                end
            end else if (rready) begin
                m_rpend = 0;
            end
            if (!m_bpend) begin
                if (awvalid && !m_aw_got) begin m_aw_got = 1; m_awaddr = awaddr; end
                if (wvalid && !m_w_got) begin m_w_got = 1; m_wdata = wdata; m_wstrb = wstrb; end
                if (m_aw_got && m_w_got) begin
                    if (hit(m_awaddr)) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[b]) m_mem[widx(m_awaddr)][8*b +: 8] = m_wdata[8*b +: 8];
                        if (m_wstrb == 4'hF) m_known[widx(m_awaddr)] = 1;
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                    m_bpend = 1; m_aw_got = 0; m_w_got = 0;
                end
            end else if (bready) begin
                m_bpend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("arready", arready, !rst && !m_rpend);
            chk("awready", awready, !rst && !m_bpend && !m_aw_got);
            chk("wready",  wready,  !rst && !m_bpend && !m_w_got);
            chk("rvalid",  rvalid,  !rst && m_rpend);
            chk("bvalid",  bvalid,  !rst && m_bpend);
            if (rst) begin
                chk("rdata_rst", rdata, 32'h0);
                chk("rresp_rst", rresp, 2'b00);
                chk("bresp_rst", bresp, 2'b00);
            end else begin
                if (m_rpend && m_rknown) chk("rdata", rdata, m_rdata);
                if (m_rpend) chk("rresp", rresp, m_rresp);
                if (m_bpend) chk("bresp", bresp, m_bresp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp);
        bit ad = 0, wd = 0;
        int t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while (!(ad && wd)) begin
            @(negedge clk);
            if (awvalid && awready) ad = 1;
            if (wvalid && wready) wd = 1;
            @(posedge clk); #1;
            if (ad) awvalid = 0;
            if (wd) wvalid = 0;
            if (++t > 50) begin timeout("wr_addr_data"); awvalid = 0; wvalid = 0; break; end
        end
        t = 0;
        @(negedge clk);
        while (!bvalid && t < 50) begin t++; @(negedge clk); end
        if (!bvalid) timeout("wr_bvalid");
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t = 0;
        araddr = a; arvalid = 1; rready = 1;
        @(negedge clk);
        while (!arready && t < 50) begin t++; @(negedge clk); end
        if (!arready) timeout("rd_arready");
        @(posedge clk); #1;
        arvalid = 0;
        t = 0;
        @(negedge clk);
        while (!rvalid && t < 50) begin t++; @(negedge clk); end
        if (!rvalid) timeout("rd_rvalid");
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic split(input bit w_first, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        awaddr = a; wdata = d; wstrb = 4'hF; bready = 0;
        if (w_first) wvalid = 1; else awvalid = 1;
        @(posedge clk); #1;
        wvalid = 0; awvalid = 0;
        repeat (2) begin
            @(negedge clk);
            chk(w_first ? "split_wready_low" : "split_awready_low",
                w_first ? wready : awready, 1'b0);
            chk("split_bvalid_early", bvalid, 1'b0);
            @(posedge clk); #1;
        end
        if (w_first) awvalid = 1; else wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("split_bvalid", bvalid, 1'b1);
        chk("split_bresp", bresp, 2'b00);
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        rd(a, rd_d, rd_r);
        chk("split_readback", rd_d, d);
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if (r == 7) return BASE + 32'hFFC;
        if (r == 8) return BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
        return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] first_rdata;
        bit far, faw, fw;

        rst = 1; arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
        araddr = 0; awaddr = 0; wdata = 0; wstrb = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_reset_arready", arready, 1'b1);
        chk("post_reset_awready", awready, 1'b1);
        chk("post_reset_rdata", rdata, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            wr(BASE + 32'(4 * i), 32'h5A00_0000 + 32'(i), 4'hF, r);
        end
        wr(BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, r);

        // write then read
        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, r);
        chk("wr10_bresp", r, 2'b00);
        rd(BASE + 32'h10, d, r);
        chk("rd10_data", d, 32'hDEAD_BEEF);
        chk("rd10_resp", r, 2'b00);

        // byte strobes
        wr(BASE + 32'h20, 32'h1122_3344, 4'hF, r);
        wr(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, r);
        rd(BASE + 32'h22, d, r);
        chk("strobe_data", d, 32'h11BB_33DD);

        // wstrb=0 leaves the word unchanged but still answers OKAY
        wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, r);
        chk("strb0_bresp", r, 2'b00);
        rd(BASE + 32'h20, d, r);
        chk("strb0_data", d, 32'h11BB_33DD);

        split(1'b1, BASE + 32'h28, 32'h0BAD_F00D);
        split(1'b0, BASE + 32'h2C, 32'h1357_9BDF);

        // out of range
        rd(BASE + 32'h1000, d, r);
        chk("oor_rdata", d, 32'h0);
        chk("oor_rresp", r, 2'b10);
        wr(BASE + 32'h1000, 32'h1234_5678, 4'hF, r);
        chk("oor_bresp", r, 2'b10);
        rd(BASE + 32'h0, d, r);
        chk("oor_word0", d, 32'h5A00_0000);
        rd(BASE + 32'hFFC, d, r);
        chk("oor_wordFFC", d, 32'hCAFE_F00D);
        chk("last_word_resp", r, 2'b00);

        // read backpressure with a concurrent write
        araddr = BASE + 32'h10; arvalid = 1; rready = 0;
        @(posedge clk); #1;
        arvalid = 0;
        awaddr = BASE + 32'h24; wdata = 32'h2468_ACE0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        bready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) first_rdata = rdata;
            chk("bp_rvalid", rvalid, 1'b1);
            chk("bp_rdata", rdata, 32'hDEAD_BEEF);
            chk("bp_rdata_stable", rdata, first_rdata);
            chk("bp_arready", arready, 1'b0);
            if (i >= 1) chk("bp_bvalid", bvalid, 1'b1);
            @(posedge clk); #1;
            awvalid = 0; wvalid = 0;
        end
        rready = 1; bready = 1;
        @(posedge clk); #1;
        rready = 0; bready = 0;
        rd(BASE + 32'h24, d, r);
        chk("bp_write_data", d, 32'h2468_ACE0);

        // reset with B pending and a second AR waiting
        awaddr = BASE + 32'h30; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = BASE + 32'h30; arvalid = 1; rready = 0; bready = 0;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("mid_bvalid", bvalid, 1'b1);
        chk("mid_rvalid", rvalid, 1'b1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        @(posedge clk); #1;
        rst = 0; rready = 1;
        @(negedge clk);
        chk("rel_arready", arready, 1'b1);
        chk("rel_awready", awready, 1'b1);
        chk("rel_wready", wready, 1'b1);
        @(posedge clk); #1;
        arvalid = 0;
        @(negedge clk);
        chk("rel_rdata_kept", rdata, 32'h0000_0077);
        @(posedge clk); #1;
        rready = 0;

        // half-captured W is discarded by reset
        wdata = 32'h0000_0BAD; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0; awaddr = BASE + 32'h34; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        @(negedge clk);
        chk("discard_no_bvalid", bvalid, 1'b0);
        @(posedge clk); #1;
        wdata = 32'h0000_1234; wvalid = 1; bready = 1;
        @(posedge clk); #1;
        wvalid = 0;
        @(negedge clk);
        chk("discard_bvalid", bvalid, 1'b1);
        @(posedge clk); #1;
        bready = 0;
        rd(BASE + 32'h34, d, r);
        chk("discard_data", d, 32'h0000_1234);

        // randomized concurrent traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            far = arvalid && arready;
            faw = awvalid && awready;
            fw  = wvalid && wready;
            @(posedge clk); #1;
            if (!arvalid || far) begin arvalid = 1'($urandom_range(0, 1)); araddr = rnd_addr(); end
            if (!awvalid || faw) begin awvalid = 1'($urandom_range(0, 1)); awaddr = rnd_addr(); end
            if (!wvalid || fw) begin
                wvalid = 1'($urandom_range(0, 1));
                wdata  = $urandom;
                wstrb  = 4'($urandom_range(0, 15));
            end
            rready = ($urandom_range(0, 3) != 0);
            bready = ($urandom_range(0, 3) != 0);
        end
        arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
